// File: rtl/shared_reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arb_pkg
// Description : Shared types, limits and helpers for the shared register
//               arbiter: FSM state encoding, the hold-window limit and a
//               one-hot index decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    localparam int MAX_HOLD  = 15;
    localparam int c_max_req = 16;

    // Returns a c_max_req-wide vector with only bit idx set. Indices at or
    // beyond n give all zeros. Callers narrow the result to their own width.
    function automatic logic [c_max_req-1:0] onehot(input int unsigned idx,
                                                    input int unsigned n);
        logic [c_max_req-1:0] v;
        v = '0;
        if (idx < n && idx < c_max_req) begin
            v[idx[3:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shared_reg_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arb_pick
// Description : Combinational winner selection. Scans the request vector
//               upward from i_ptr, wrapping at N_REQ-1, and returns the first
//               asserted index.
//               With SHARED_REG_ARB_FIXED_PRIO_EN defined the pointer is tied
//               to 0, giving fixed lowest-index-wins priority.
// Ports       : i_req  - request vector
//               i_ptr  - scan start index
//               o_idx  - winning index (0 when o_vld is low)
//               o_vld  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arb_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    logic [IDX_W-1:0] w_ptr;

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
    logic w_ptr_unused;
    assign w_ptr_unused = ^i_ptr;
    assign w_ptr        = '0;
`else
    assign w_ptr = i_ptr;
`endif

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_cand = IDX_W'((32'(w_ptr) + 32'(off)) % 32'(N_REQ));
            if (!o_vld && i_req[w_cand]) begin
                o_vld = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shared_reg_arb.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arb
// Description : Round-robin arbiter/sequencer for one shared latch-style
//               register. A winner is picked in IDLE, its data captured and
//               the latch enable held open for HOLD_CYCLES cycles, then a
//               one-cycle ack is returned to the winner.
//               Macro SHARED_REG_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins, no rotation pointer).
// Ports       : i_clk   - clock
//               i_srst  - synchronous reset, active high
//               i_req   - per-requester request level
//               i_data  - per-requester write data, slice k = [k*W +: W]
//               o_gnt   - one-hot grant (OPEN and ACK)
//               o_ack   - one-hot completion pulse
//               o_en    - latch enable
//               o_d     - latch data
//               o_busy  - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arb
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_srst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_data,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_en,
    output logic [W-1:0]       o_d,
    output logic               o_busy
);

    localparam int c_idx_w = $clog2(N_REQ);
    localparam int c_cnt_w = $clog2(MAX_HOLD + 1);
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(N_REQ - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;
    logic [c_idx_w-1:0] r_win,   w_win_nxt;
    logic [N_REQ-1:0]   r_gnt,   w_gnt_nxt;
    logic [N_REQ-1:0]   r_ack,   w_ack_nxt;
    logic               r_en,    w_en_nxt;
    logic [W-1:0]       r_d,     w_d_nxt;

    logic [c_idx_w-1:0] w_pick_ptr;
    logic [c_idx_w-1:0] w_pick_idx;
    logic               w_pick_vld;

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
    assign w_pick_ptr = '0;
`else
    // Rotation pointer: the served requester drops to lowest priority.
    logic [c_idx_w-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_ptr <= '0;
        end else if (r_state == ST_ACK) begin
            r_ptr <= (r_win == c_last_idx) ? '0 : r_win + 1'b1;
        end
    end

    assign w_pick_ptr = r_ptr;
`endif

    shared_reg_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_idx_w)
    ) u_pick (
        .i_req (i_req),
        .i_ptr (w_pick_ptr),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_en    <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_en    <= w_en_nxt;
            r_d     <= w_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_win_nxt   = r_win;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_en_nxt    = r_en;
        w_d_nxt     = r_d;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_OPEN;
                    w_win_nxt   = w_pick_idx;
                    w_gnt_nxt   = N_REQ'(onehot(32'(w_pick_idx), N_REQ));
                    w_d_nxt     = i_data[32'(w_pick_idx) * W +: W];
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = c_hold_load;
                end
            end
            ST_OPEN: begin
                // Counter counts remaining open cycles after the current one.
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                    w_en_nxt    = 1'b0;
                    w_ack_nxt   = N_REQ'(onehot(32'(r_win), N_REQ));
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    assign o_gnt  = r_gnt;
    assign o_ack  = r_ack;
    assign o_en   = r_en;
    assign o_d    = r_d;
    assign o_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_reg_arb
// Description : Self-checking bench for shared_reg_arb. A transaction-level
//               reference (phase count since arbitration, rotating pointer)
//               predicts every output each cycle; directed sequences add
//               grant-order, spacing and data-hold checks, followed by a
//               randomized run with sporadic resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arb;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 2;

    logic           clk = 1'b0;
    logic           srst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   o_gnt;
    logic [N-1:0]   o_ack;
    logic           o_en;
    logic [W-1:0]   o_d;
    logic           o_busy;

    always #5 clk = ~clk;

    shared_reg_arb #(
        .N_REQ       (N),
        .W           (W),
        .HOLD_CYCLES (H)
    ) dut (
        .i_clk  (clk),
        .i_srst (srst),
        .i_req  (req),
        .i_data (data),
        .o_gnt  (o_gnt),
        .o_ack  (o_ack),
        .o_en   (o_en),
        .o_d    (o_d),
        .o_busy (o_busy)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc_n = 0;

    // Reference model: phase 0 = idle, 1..H = enable window, H+1 = ack.
    int           m_phase = 0;
    int           m_ptr   = 0;
    int           m_win   = 0;
    logic [W-1:0] m_d     = '0;

    logic [N-1:0] gnt_q[$];
    int           gtime_q[$];
    logic [N-1:0] prev_gnt = '0;
    int           ack_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc_n, obs, exp);
        end
    endtask

    function automatic int ref_pick(input logic [N-1:0] r, input int ptr);
        logic [2*N-1:0] dbl;
        int p;
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
        p = 0;
`else
        p = ptr;
`endif
        dbl = {r, r} >> p;
        for (int i = 0; i < N; i++) begin
            if (dbl[i]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic cyc(input logic s, input logic [N-1:0] r, input logic [N*W-1:0] d);
        logic [N-1:0] e_oh;
        srst = s;
        req  = r;
        data = d;
        @(posedge clk);
        cyc_n++;
        if (s) begin
            m_phase = 0;
            m_ptr   = 0;
            m_d     = '0;
        end else if (m_phase == 0) begin
            if (r != '0) begin
                m_win   = ref_pick(r, m_ptr);
                m_d     = d[m_win*W +: W];
                m_phase = 1;
            end
        end else if (m_phase <= H) begin
            m_phase++;
        end else begin
            m_phase = 0;
            m_ptr   = (m_win + 1) % N;
        end
        #1;
        e_oh = (m_phase != 0) ? (N'(1) << m_win) : '0;
        check("gnt",  o_gnt,  e_oh);
        check("en",   o_en,   (m_phase >= 1 && m_phase <= H));
        check("ack",  o_ack,  (m_phase == H + 1) ? e_oh : '0);
        check("busy", o_busy, (m_phase != 0));
        check("d",    o_d,    m_d);
        if (prev_gnt == '0 && o_gnt != '0) begin
            gnt_q.push_back(o_gnt);
            gtime_q.push_back(cyc_n);
        end
        prev_gnt = o_gnt;
        if (o_ack != '0) ack_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] dv;
        logic [N-1:0]   exp_rr[4];
        logic [N-1:0]   exp_wrap[2];
        logic [N-1:0]   exp_1011[4];
        int             seen;
        int             n_en;
        int             ack0;

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
        exp_rr   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_wrap = '{4'b0001, 4'b0001};
        exp_1011 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_wrap = '{4'b1000, 4'b0001};
        exp_1011 = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
        srst = 1'b1;
        req  = '0;
        data = '0;

        // Reset state
        cyc(1'b1, '0, '0);
        cyc(1'b1, '0, '0);
        check("rst_gnt",  o_gnt,  0);
        check("rst_ack",  o_ack,  0);
        check("rst_en",   o_en,   0);
        check("rst_d",    o_d,    0);
        check("rst_busy", o_busy, 0);

        // Single request from requester 2
        dv = '0;
        dv[2*W +: W] = 8'hA5;
        seen = 0;
        n_en = 0;
        for (int i = 0; i < 12 && seen == 0; i++) begin
            cyc(1'b0, 4'b0100, dv);
            if (o_en) begin
                n_en++;
                check("single_d",   o_d,   8'hA5);
                check("single_gnt", o_gnt, 4'b0100);
            end
            if (o_ack != '0) begin
                seen = 1;
                check("single_ack", o_ack, 4'b0100);
            end
        end
        check("single_seen",   seen, 1);
        check("single_en_len", n_en, H);
        cyc(1'b0, '0, dv);
        check("single_idle", o_busy, 0);

        // Reset in the first OPEN cycle
        cyc(1'b0, 4'b0010, $urandom);
        check("rmo_open", o_en, 1);
        ack0 = ack_cnt;
        cyc(1'b1, 4'b0010, $urandom);
        check("rmo_en",   o_en,   0);
        check("rmo_gnt",  o_gnt,  0);
        check("rmo_busy", o_busy, 0);
        repeat (6) cyc(1'b0, '0, $urandom);
        check("rmo_no_ack", ack_cnt, ack0);
        gnt_q.delete();
        cyc(1'b0, 4'b1001, $urandom);
        check("rmo_ptr0", o_gnt, 4'b0001);
        repeat (H + 1) cyc(1'b0, 4'b1001, $urandom);
        cyc(1'b0, '0, $urandom);

        // All four requesting continuously, 16 transactions
        cyc(1'b1, '0, '0);
        gnt_q.delete();
        gtime_q.delete();
        repeat (16 * (H + 2)) cyc(1'b0, 4'b1111, $urandom);
        check("rr_count", gnt_q.size(), 16);
        for (int i = 0; i < gnt_q.size(); i++) begin
            check("rr_order", gnt_q[i], exp_rr[i % 4]);
            if (i > 0) check("rr_space", gtime_q[i] - gtime_q[i-1], H + 2);
        end

        // Wrap: pointer at 3, requests 0 and 3
        cyc(1'b1, '0, '0);
        ack0 = ack_cnt;
        for (int i = 0; i < 12 && ack_cnt == ack0; i++) cyc(1'b0, 4'b0100, $urandom);
        cyc(1'b0, '0, $urandom);
        gnt_q.delete();
        ack0 = ack_cnt;
        for (int i = 0; i < 4 * (H + 2) + 4 && ack_cnt < ack0 + 2; i++) begin
            cyc(1'b0, 4'b1001, $urandom);
        end
        cyc(1'b0, '0, $urandom);
        check("wrap_count", gnt_q.size(), 2);
        check("wrap_first",  gnt_q[0], exp_wrap[0]);
        check("wrap_second", gnt_q[1], exp_wrap[1]);

        // req = 1011 held from reset
        cyc(1'b1, '0, '0);
        gnt_q.delete();
        repeat (4 * (H + 2)) cyc(1'b0, 4'b1011, $urandom);
        check("p1011_count", gnt_q.size(), 4);
        for (int i = 0; i < gnt_q.size(); i++) check("p1011_order", gnt_q[i], exp_1011[i]);

        // Request drop and data change during OPEN
        dv = $urandom;
        dv[W +: W] = 8'h3C;
        cyc(1'b0, 4'b0010, dv);
        check("drop_d0", o_d, 8'h3C);
        dv[W +: W] = 8'hFF;
        seen = 0;
        for (int i = 0; i < 12 && seen == 0; i++) begin
            cyc(1'b0, '0, dv);
            if (o_en) check("drop_d", o_d, 8'h3C);
            if (o_ack != '0) begin
                seen = 1;
                check("drop_ack", o_ack, 4'b0010);
            end
        end
        check("drop_seen", seen, 1);
        cyc(1'b0, '0, dv);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), N'($urandom_range(0, 15)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
